// File: rtl/led_switch_panel.sv
// Switch-to-LED front panel: per-channel 2-flop sync, debounce, follow/toggle LED, rise pulses, heartbeat.
// Optional LED_PWM_EN adds an 8-bit PWM dimmer on the channel LEDs, controlled by BRIGHTNESS.
module led_switch_panel #(
   parameter int                NUM_SW          = 4,
   parameter int                DEBOUNCE_CYCLES = 250000,
   parameter int                HB_WIDTH        = 26,
   parameter logic [NUM_SW-1:0] TOGGLE_MASK     = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_SW-1:0] SW,
`ifdef LED_PWM_EN
   input  logic [7:0]        BRIGHTNESS,
`endif
   output logic [NUM_SW:0]   LED,
   output logic [NUM_SW-1:0] SW_RISE
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0]          sync1_q, sync2_q;
   logic [NUM_SW-1:0]          stable_q, stable_d;
   logic [NUM_SW-1:0][CW-1:0]  cnt_q, cnt_d;
   logic [NUM_SW-1:0]          rise_q, rise_d;
   logic [NUM_SW-1:0]          tog_q, tog_d;
   logic [HB_WIDTH-1:0]        hb_q;
   logic [NUM_SW-1:0]          base;
   logic                       pwm_on;

   // Debounce: stable only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < NUM_SW; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      rise_d = stable_d & ~stable_q;
      tog_d  = tog_q ^ (rise_d & TOGGLE_MASK);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         rise_q   <= '0;
         tog_q    <= '0;
         hb_q     <= '0;
      end else begin
         sync1_q  <= SW;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         tog_q    <= tog_d;
         hb_q     <= hb_q + HB_WIDTH'(1);
      end
   end

`ifdef LED_PWM_EN
   logic [7:0] pwm_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) pwm_q <= '0;
      else     pwm_q <= pwm_q + 8'd1;
   end

   assign pwm_on = (pwm_q < BRIGHTNESS);
`else
   assign pwm_on = 1'b1;
`endif

   assign base    = (TOGGLE_MASK & tog_q) | (~TOGGLE_MASK & stable_q);
   assign LED     = {hb_q[HB_WIDTH-1], base & {NUM_SW{pwm_on}}};
   assign SW_RISE = rise_q;

endmodule

// File: tb/tb_led_switch_panel.sv
// Bench for led_switch_panel: directed vector table, heartbeat/PWM sequences and random stimulus
// against a window-based reference model (define LED_PWM_EN to cover the dimmer).
module tb_led_switch_panel;

   localparam int         NSW  = 4;
   localparam int         DEB  = 8;
   localparam logic [3:0] MASK = 4'b1000;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] SW;
   logic [4:0] LED;
   logic [3:0] SW_RISE;
`ifdef LED_PWM_EN
   logic [7:0] BRIGHTNESS;
`endif

   led_switch_panel #(
      .NUM_SW(NSW), .DEBOUNCE_CYCLES(DEB), .HB_WIDTH(4), .TOGGLE_MASK(MASK)
   ) dut (
      .CLK(CLK), .RST(RST), .SW(SW),
`ifdef LED_PWM_EN
      .BRIGHTNESS(BRIGHTNESS),
`endif
      .LED(LED), .SW_RISE(SW_RISE)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: a switch level is accepted once DEB consecutive synchronised samples disagree.
   logic [3:0] st_m, tog_m, rise_m;
   int         cyc_m;
   logic [3:0] dly[$];
   logic [3:0] hist[$];

   task automatic model_reset();
      st_m = '0; tog_m = '0; rise_m = '0; cyc_m = 0;
      dly = {4'h0, 4'h0};
      hist = {};
   endtask

   task automatic model_edge();
      logic [3:0] din, nst;
      bit all;
      if (RST) begin
         model_reset();
         return;
      end
      din = dly[0];
      dly.delete(0);
      dly.push_back(SW);
      hist.push_back(din);
      if (hist.size() > DEB) hist.delete(0);
      nst = st_m;
      if (hist.size() == DEB) begin
         for (int i = 0; i < NSW; i++) begin
            all = 1;
            for (int j = 0; j < DEB; j++) if (hist[j][i] == st_m[i]) all = 0;
            if (all) nst[i] = ~st_m[i];
         end
      end
      rise_m = nst & ~st_m;
      tog_m  = tog_m ^ (rise_m & MASK);
      st_m   = nst;
      cyc_m++;
   endtask

   function automatic logic pwm_on_m();
`ifdef LED_PWM_EN
      return (cyc_m % 256) < int'(BRIGHTNESS);
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [4:0] exp_led();
      logic [3:0] base;
      base = (MASK & tog_m) | (~MASK & st_m);
      return {((cyc_m % 16) >= 8), base & {4{pwm_on_m()}}};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      chk("led_model", 32'(LED), 32'(exp_led()));
      chk("rise_model", 32'(SW_RISE), 32'(rise_m));
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] sw;
      int         n;
      logic [3:0] led;
      logic [3:0] rise;
   } vec_t;

   vec_t tbl[24];
   int   c0, c4;

   initial begin
      tbl[0]  = '{1'b1, 4'hF,  3, 4'h0, 4'h0};  // reset with switches held
      tbl[1]  = '{1'b0, 4'hF,  9, 4'h0, 4'h0};
      tbl[2]  = '{1'b0, 4'hF,  1, 4'hF, 4'hF};  // 10th edge after release
      tbl[3]  = '{1'b0, 4'hF,  1, 4'hF, 4'h0};
      tbl[4]  = '{1'b0, 4'hE, 20, 4'hE, 4'h0};
      tbl[5]  = '{1'b0, 4'hF,  5, 4'hE, 4'h0};  // 5-cycle glitch
      tbl[6]  = '{1'b0, 4'hE, 12, 4'hE, 4'h0};
      tbl[7]  = '{1'b0, 4'hF,  9, 4'hE, 4'h0};
      tbl[8]  = '{1'b0, 4'hF,  1, 4'hF, 4'h1};
      tbl[9]  = '{1'b0, 4'h7, 20, 4'hF, 4'h0};  // toggle release: no effect
      tbl[10] = '{1'b0, 4'hF,  9, 4'hF, 4'h0};
      tbl[11] = '{1'b0, 4'hF,  1, 4'h7, 4'h8};  // second press toggles off
      tbl[12] = '{1'b0, 4'h7, 20, 4'h7, 4'h0};
      tbl[13] = '{1'b0, 4'h0, 20, 4'h0, 4'h0};
      tbl[14] = '{1'b0, 4'h7,  9, 4'h0, 4'h0};
      tbl[15] = '{1'b0, 4'h7,  1, 4'h7, 4'h7};  // simultaneous rise
      tbl[16] = '{1'b0, 4'h0, 20, 4'h0, 4'h0};
      tbl[17] = '{1'b0, 4'h7,  6, 4'h0, 4'h0};  // counters at 4
      tbl[18] = '{1'b1, 4'h7,  2, 4'h0, 4'h0};
      tbl[19] = '{1'b0, 4'h0, 15, 4'h0, 4'h0};  // no stale update
      tbl[20] = '{1'b0, 4'h7,  4, 4'h0, 4'h0};
      tbl[21] = '{1'b1, 4'h7,  1, 4'h0, 4'h0};
      tbl[22] = '{1'b0, 4'h7,  9, 4'h0, 4'h0};
      tbl[23] = '{1'b0, 4'h7,  1, 4'h7, 4'h7};  // fresh rise after reset

      RST = 1'b1;
      SW  = 4'h0;
`ifdef LED_PWM_EN
      BRIGHTNESS = 8'd255;
`endif
      model_reset();
      @(negedge CLK);
      #1;
      chk("reset_led", 32'(LED), 32'h0);
      chk("reset_rise", 32'(SW_RISE), 32'h0);

      for (int v = 0; v < 24; v++) begin
         RST = tbl[v].rst;
         SW  = tbl[v].sw;
         for (int c = 0; c < tbl[v].n; c++) step();
         chk($sformatf("tbl%0d_led", v), 32'(LED[3:0]), 32'(tbl[v].led & {4{pwm_on_m()}}));
         chk($sformatf("tbl%0d_rise", v), 32'(SW_RISE), 32'(tbl[v].rise));
      end

      // Heartbeat: 8 low, 8 high from reset; async reset clears it mid-period.
      RST = 1'b1; SW = 4'h0;
      step();
      RST = 1'b0;
      for (int k = 1; k <= 44; k++) begin
         step();
         chk("hb", 32'(LED[4]), 32'((k % 16) >= 8));
      end
      RST = 1'b1;
      #1;
      chk("hb_async_rst", 32'(LED), 32'h0);
      step();
      RST = 1'b0;

`ifdef LED_PWM_EN
      BRIGHTNESS = 8'd128;
`endif
      for (int r = 0; r < 600; r++) begin
         RST = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 5) == 0) SW = 4'($urandom);
         step();
      end

`ifdef LED_PWM_EN
      RST = 1'b1; step();
      RST = 1'b0; SW = 4'h1; BRIGHTNESS = 8'd64;
      repeat (20) step();
      c0 = 0; c4 = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         c0 += int'(LED[0]);
         c4 += int'(LED[4]);
      end
      chk("pwm64_on", 32'(c0), 32'd64);
      chk("pwm64_hb", 32'(c4), 32'd128);
      BRIGHTNESS = 8'd0;
      c0 = 0; c4 = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         c0 += int'(LED[0]);
         c4 += int'(LED[4]);
      end
      chk("pwm0_on", 32'(c0), 32'd0);
      chk("pwm0_hb", 32'(c4), 32'd128);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
